narnn_trace_sequencer: RTL

- Synthesizable on-chip stimulus/capture engine for the NAR-Net core.
- Holds a loadable trace of fixed-point Q-format samples and issues them one at a time to the core using the x_ready / out_ready handshake.
- Captures each y_out into a result buffer, which a host can read back.
- Generalises the trace replay loop: parametrised width and depth, programmable run length, response timeout, and optional closed-loop (multi-step prediction) mode.

---
 rtl/narnn_pkg.sv | 10 +
 rtl/narnn_sdp_ram.sv | 25 ++
 rtl/narnn_trace_sequencer.sv | 115 +++++++++++
 3 files changed

// File: rtl/narnn_pkg.sv
// narnn_pkg: shared defaults, state encoding and sample type for the NAR-Net trace sequencer
package narnn_pkg;
  localparam int N_DEF = 8;
  localparam int Q_DEF = 7;
  localparam int DEPTH_DEF = 298;
  localparam int TIMEOUT_DEF = 1024;
  localparam int AW_DEF = $clog2(DEPTH_DEF);
  typedef logic signed [N_DEF-1:0] sample_t;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, STORE, DONE, ERR} state_t;
endpackage

// File: rtl/narnn_sdp_ram.sv
// narnn_sdp_ram: simple dual-port synchronous RAM, one write port, one registered read port
// Ports: clk, rst_n (clears the read register only), we/waddr/wdata write port,
//        raddr/rdata read port with 1-cycle latency; a same-cycle write to raddr returns old data.
module narnn_sdp_ram
  import narnn_pkg::*;
#(
  parameter int W = N_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else rdata <= mem[raddr];
endmodule

// File: rtl/narnn_trace_sequencer.sv
// narnn_trace_sequencer: replays a loaded sample trace into the NAR-Net core and captures its outputs
// Ports: clk, rst_n (async active-low); start/run_len begin a run; load_we/load_addr/load_data fill
//        the trace while idle; rd_addr/rd_data read results (1-cycle latency); core_x_in/core_x_ready
//        issue a sample, core_y_out/core_out_ready return it; busy, done, timeout_err, sample_cnt report.
// Option: NARNN_CLOSED_LOOP_EN adds closed_loop/prime_len for multi-step prediction feedback.
module narnn_trace_sequencer
  import narnn_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = $clog2(DEPTH),
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef NARNN_CLOSED_LOOP_EN
  input  logic          closed_loop,
  input  logic [AW:0]   prime_len,
`endif
  input  logic          start,
  input  logic [AW:0]   run_len,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [N-1:0]  load_data,
  input  logic [AW-1:0] rd_addr,
  output logic [N-1:0]  rd_data,
  output logic [N-1:0]  core_x_in,
  output logic          core_x_ready,
  input  logic [N-1:0]  core_y_out,
  input  logic          core_out_ready,
  output logic          busy,
  output logic          done,
  output logic          timeout_err,
  output logic [AW:0]   sample_cnt
);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state, state_nxt;
  logic [AW-1:0] idx, idx_nxt;
  logic [LW-1:0] len_l, len_c;
  logic [TW-1:0] to_cnt;
  logic [N-1:0] y_hold, trace_q, x_src;
  logic idle_st, go, last;
  assign idle_st = state inside {IDLE, DONE, ERR};
  assign go = idle_st && start;
  assign busy = !idle_st;
  assign done = state == DONE;
  assign timeout_err = state == ERR;
  assign len_c = (run_len > LW'(DEPTH)) ? LW'(DEPTH) : run_len;
  assign last = sample_cnt + 1'b1 == len_l;
  // The trace read port is addressed with the next index so trace[idx] is ready in ISSUE.
  always_comb begin
    state_nxt = state;
    idx_nxt = idx;
    case (state)
      IDLE, DONE, ERR: if (start) begin
        state_nxt = (len_c == '0) ? DONE : ISSUE;
        idx_nxt = '0;
      end
      ISSUE: state_nxt = WAIT;
      WAIT: state_nxt = core_out_ready ? STORE : (to_cnt == TW'(TIMEOUT - 1)) ? ERR : WAIT;
      STORE: begin
        state_nxt = last ? DONE : ISSUE;
        idx_nxt = last ? idx : idx + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      sample_cnt <= '0;
      len_l <= '0;
      to_cnt <= '0;
      y_hold <= '0;
      core_x_in <= '0;
      core_x_ready <= 1'b0;
    end else begin
      state <= state_nxt;
      idx <= idx_nxt;
      core_x_ready <= state == ISSUE;
      if (state == ISSUE) core_x_in <= x_src;
      to_cnt <= (state == WAIT) ? to_cnt + 1'b1 : '0;
      if (state == WAIT && core_out_ready) y_hold <= core_y_out;
      if (go) begin
        sample_cnt <= '0;
        len_l <= len_c;
      end else if (state == STORE) sample_cnt <= sample_cnt + 1'b1;
    end
`ifdef NARNN_CLOSED_LOOP_EN
  logic cl_l;
  logic [LW-1:0] prime_l;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cl_l <= 1'b0;
      prime_l <= '0;
    end else if (go) begin
      cl_l <= closed_loop;
      prime_l <= prime_len;
    end
  // Past the priming window the previous prediction is fed back; sample 0 always comes from the trace.
  assign x_src = (cl_l && idx != '0 && LW'(idx) >= prime_l) ? y_hold : trace_q;
`else
  assign x_src = trace_q;
`endif
  narnn_sdp_ram #(.W(N), .DEPTH(DEPTH), .AW(AW)) u_trace (
    .clk(clk), .rst_n(rst_n), .we(load_we && idle_st), .waddr(load_addr), .wdata(load_data),
    .raddr(idx_nxt), .rdata(trace_q)
  );
  narnn_sdp_ram #(.W(N), .DEPTH(DEPTH), .AW(AW)) u_result (
    .clk(clk), .rst_n(rst_n), .we(state == STORE), .waddr(idx), .wdata(y_hold),
    .raddr(rd_addr), .rdata(rd_data)
  );
endmodule
